// File: rtl/wb_master_engine.sv
// Wishbone B4 classic master engine: commands are queued in a small FIFO,
// executed one at a time on the bus, and answered on a valid/ready response
// channel. A per-cycle ack timeout ends a stuck cycle with an error response.
// Slave interrupts are captured into a sticky pending flag.
module wb_master_engine #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int CMD_DEPTH  = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
   input  logic [DATA_WIDTH-1:0] cmd_dat_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_we_o,
   output logic [ADDR_WIDTH-1:0] rsp_adr_o,
   output logic [DATA_WIDTH-1:0] rsp_dat_o,
   output logic                  rsp_err_o,
   output logic                  cyc_o,
   output logic                  stb_o,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] adr_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   input  logic [DATA_WIDTH-1:0] dat_i,
   input  logic                  ack_i,
   input  logic                  irq_i,
   output logic                  irq_pend_o,
   input  logic                  irq_clr_i,
   output logic                  busy_o
);

   localparam int PTR_W   = $clog2(CMD_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int TMO_W   = $clog2(TIMEOUT);
   localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(CMD_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   // Command FIFO storage and bookkeeping
   logic [ENTRY_W-1:0]    fifo_mem [CMD_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]      count_reg, count_next;
   logic                  ready_reg;
   logic                  push, pop;

   // Engine state and registered outputs
   state_t                state_reg, state_next;
   logic [TMO_W-1:0]      tmo_reg, tmo_next;
   logic                  cyc_reg, cyc_next;
   logic                  we_reg, we_next;
   logic [ADDR_WIDTH-1:0] adr_reg, adr_next;
   logic [DATA_WIDTH-1:0] dat_reg, dat_next;
   logic                  rsp_valid_reg, rsp_valid_next;
   logic                  rsp_we_reg, rsp_we_next;
   logic [ADDR_WIDTH-1:0] rsp_adr_reg, rsp_adr_next;
   logic [DATA_WIDTH-1:0] rsp_dat_reg, rsp_dat_next;
   logic                  rsp_err_reg, rsp_err_next;

   // Head-of-queue entry fields
   logic [ENTRY_W-1:0]    head;
   logic                  head_we;
   logic [ADDR_WIDTH-1:0] head_adr;
   logic [DATA_WIDTH-1:0] head_dat;

   // Interrupt capture
   logic irq_sync_reg, irq_prev_reg, irq_pend_reg;

   assign push     = cmd_valid_i && ready_reg;
   assign head     = fifo_mem[rd_ptr_reg];
   assign head_we  = head[ENTRY_W-1];
   assign head_adr = head[DATA_WIDTH +: ADDR_WIDTH];
   assign head_dat = head[DATA_WIDTH-1:0];

   // Occupancy after this edge; simultaneous push and pop leaves it unchanged
   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + CNT_W'(1);
      else if (!push && pop)
         count_next = count_reg - CNT_W'(1);
   end

   // FIFO storage write; no reset so the array can map onto RAM
   always_ff @(posedge clk_i) begin
      if (rst_i && push)
         fifo_mem[wr_ptr_reg] <= {cmd_we_i, cmd_adr_i, cmd_dat_i};
   end

   // FIFO pointers, count and the registered ready flag
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ready_reg  <= 1'b1;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_next;
         ready_reg <= (count_next < DEPTH_C);
      end
   end

   // Next-state and next-output logic for the bus engine
   always_comb begin
      state_next     = state_reg;
      pop            = 1'b0;
      tmo_next       = tmo_reg;
      cyc_next       = cyc_reg;
      we_next        = we_reg;
      adr_next       = adr_reg;
      dat_next       = dat_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_we_next    = rsp_we_reg;
      rsp_adr_next   = rsp_adr_reg;
      rsp_dat_next   = rsp_dat_reg;
      rsp_err_next   = rsp_err_reg;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) begin
               pop        = 1'b1;
               cyc_next   = 1'b1;
               we_next    = head_we;
               adr_next   = head_adr;
               dat_next   = head_we ? head_dat : '0;
               tmo_next   = '0;
               state_next = REQ;
            end
         end
         REQ: begin
            // Ack takes priority over the timeout on the same edge
            if (ack_i || (tmo_reg == TMO_LAST_C)) begin
               cyc_next       = 1'b0;
               we_next        = 1'b0;
               adr_next       = '0;
               dat_next       = '0;
               rsp_valid_next = 1'b1;
               rsp_we_next    = we_reg;
               rsp_adr_next   = adr_reg;
               rsp_err_next   = !ack_i;
               if (!ack_i)
                  rsp_dat_next = '0;
               else if (we_reg)
                  rsp_dat_next = dat_reg;
               else
                  rsp_dat_next = dat_i;
               state_next = RSP;
            end else begin
               tmo_next = tmo_reg + TMO_W'(1);
            end
         end
         RSP: begin
            if (rsp_ready_i) begin
               rsp_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Engine state register; reset abandons any cycle in flight
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_reg     <= IDLE;
         tmo_reg       <= '0;
         cyc_reg       <= 1'b0;
         we_reg        <= 1'b0;
         adr_reg       <= '0;
         dat_reg       <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_we_reg    <= 1'b0;
         rsp_adr_reg   <= '0;
         rsp_dat_reg   <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         tmo_reg       <= tmo_next;
         cyc_reg       <= cyc_next;
         we_reg        <= we_next;
         adr_reg       <= adr_next;
         dat_reg       <= dat_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_we_reg    <= rsp_we_next;
         rsp_adr_reg   <= rsp_adr_next;
         rsp_dat_reg   <= rsp_dat_next;
         rsp_err_reg   <= rsp_err_next;
      end
   end

   // Register irq once, then latch a rising edge; a new edge beats a clear
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         irq_sync_reg <= 1'b0;
         irq_prev_reg <= 1'b0;
         irq_pend_reg <= 1'b0;
      end else begin
         irq_sync_reg <= irq_i;
         irq_prev_reg <= irq_sync_reg;
         if (irq_sync_reg && !irq_prev_reg)
            irq_pend_reg <= 1'b1;
         else if (irq_clr_i)
            irq_pend_reg <= 1'b0;
      end
   end

   assign cmd_ready_o = ready_reg;
   assign cyc_o       = cyc_reg;
   assign stb_o       = cyc_reg;
   assign we_o        = we_reg;
   assign adr_o       = adr_reg;
   assign dat_o       = dat_reg;
   assign rsp_valid_o = rsp_valid_reg;
   assign rsp_we_o    = rsp_we_reg;
   assign rsp_adr_o   = rsp_adr_reg;
   assign rsp_dat_o   = rsp_dat_reg;
   assign rsp_err_o   = rsp_err_reg;
   assign irq_pend_o  = irq_pend_reg;
   assign busy_o      = (state_reg != IDLE) || (count_reg != '0);

endmodule
